// File: rtl/write_buffer_pkg.sv
// Shared types for the write-through store buffer: widths, entry layout, drain states.
package write_buffer_pkg;

    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 8;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        WB_IDLE  = 1'b0,
        WB_WRITE = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Priority address match over the queued entries; the youngest match (nearest tail) wins.
module wb_fwd_match
    import write_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W
) (
    input  wb_entry_t                  entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   head,
    input  logic [$clog2(DEPTH):0]     count,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic                       hit,
    output logic [DATA_W-1:0]          data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] idx;

    // Scan oldest to youngest; a later match overrides, so the entry nearest tail wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if ((CNT_W'(k) < count) && (entries[idx].addr == rd_addr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/write_buffer.sv
// Write-through store buffer: FIFO of cache stores drained to a single RAM write port.
// Read forwarding from queued entries is present only when WB_FORWARD_EN is defined.
module write_buffer
    import write_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_req,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_data,
    input  logic                     ram_grant,
    output logic [ADDR_W-1:0]        ram_address,
    output logic [DATA_W-1:0]        ram_data,
    output logic                     ram_wren,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    wb_state_t        state;
    wb_state_t        state_next;
    logic             push;
    logic             pop;
    logic             load;

    // A pop in the same cycle does not open a slot until the next cycle.
    assign wr_ready = (count < CNT_W'(DEPTH));
    assign push     = wr_req && wr_ready;
    assign empty    = (count == '0) && (state == WB_IDLE);

    always_comb begin
        state_next = state;
        load       = 1'b0;
        pop        = 1'b0;
        case (state)
            WB_IDLE: begin
                if ((count != '0) && ram_grant) begin
                    load       = 1'b1;
                    state_next = WB_WRITE;
                end
            end
            WB_WRITE: begin
                pop        = 1'b1;
                state_next = WB_IDLE;
            end
            default: state_next = WB_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= WB_IDLE;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage carries no reset; validity is defined by head/count.
    always_ff @(posedge clock) begin
        if (push) mem[tail] <= '{addr: wr_addr, data: wr_data};
    end

    // RAM port stage: registered address/data/enable, held until the next load.
    always_ff @(posedge clock) begin
        if (reset) begin
            ram_wren    <= 1'b0;
            ram_address <= '0;
            ram_data    <= '0;
        end else begin
            ram_wren <= load;
            if (load) begin
                ram_address <= mem[head].addr;
                ram_data    <= mem[head].data;
            end
        end
    end

`ifdef WB_FORWARD_EN
    wb_fwd_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fwd_match (
        .entries (mem),
        .head    (head),
        .count   (count),
        .rd_addr (rd_addr),
        .hit     (fwd_hit),
        .data    (fwd_data)
    );
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr;
    assign fwd_hit        = 1'b0;
    assign fwd_data       = '0;
`endif

endmodule

// File: tb/tb_write_buffer.sv
// Directed self-checking bench for write_buffer (forwarding expectations follow WB_FORWARD_EN).
module tb_write_buffer;

    logic       clock = 1'b0;
    logic       reset;
    logic       wr_req;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [4:0] rd_addr;
    logic       fwd_hit;
    logic [7:0] fwd_data;
    logic       ram_grant;
    logic [4:0] ram_address;
    logic [7:0] ram_data;
    logic       ram_wren;
    logic [2:0] count;
    logic       empty;

    int tests  = 0;
    int failed = 0;

`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    write_buffer #(.DEPTH(4), .ADDR_W(5), .DATA_W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .rd_addr     (rd_addr),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data),
        .ram_grant   (ram_grant),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .count       (count),
        .empty       (empty)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [4:0] a, input logic [7:0] d);
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_req  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr = '0; ram_grant = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        chk("rst_count", count, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_wren", ram_wren, 0);
        chk("rst_ram_addr", ram_address, 0);
        chk("rst_ram_data", ram_data, 0);
        chk("rst_fwd_hit", fwd_hit, 0);
        chk("rst_fwd_data", fwd_data, 0);

        // Single store with grant high
        ram_grant = 1'b1;
        push(5'h0A, 8'h5C);
        chk("single_cnt_e1", count, 1);
        chk("single_empty_e1", empty, 0);
        chk("single_wren_e1", ram_wren, 0);
        tick();
        chk("single_wren_e2", ram_wren, 1);
        chk("single_addr_e2", ram_address, 5'h0A);
        chk("single_data_e2", ram_data, 8'h5C);
        tick();
        chk("single_wren_e3", ram_wren, 0);
        chk("single_cnt_e3", count, 0);
        chk("single_empty_e3", empty, 1);

        // Fill to full with grant low; fifth store is dropped
        ram_grant = 1'b0;
        push(5'h01, 8'h10);
        push(5'h02, 8'h20);
        push(5'h03, 8'h30);
        push(5'h04, 8'h40);
        chk("full_cnt", count, 4);
        chk("full_ready", wr_ready, 0);
        push(5'h1F, 8'hFF);
        chk("drop_cnt", count, 4);
        ram_grant = 1'b1;
        tick();
        chk("drain0_wren", ram_wren, 1);
        chk("drain0_addr", ram_address, 5'h01);
        chk("drain0_data", ram_data, 8'h10);
        chk("drain0_ready_full", wr_ready, 0);
        tick();
        chk("drain0_pop_cnt", count, 3);
        chk("drain0_pop_ready", wr_ready, 1);
        chk("drain0_pop_wren", ram_wren, 0);
        tick();
        chk("drain1_addr", ram_address, 5'h02);
        chk("drain1_data", ram_data, 8'h20);
        tick();
        chk("drain1_cnt", count, 2);
        tick();
        chk("drain2_addr", ram_address, 5'h03);
        chk("drain2_data", ram_data, 8'h30);
        tick();
        tick();
        chk("drain3_addr", ram_address, 5'h04);
        chk("drain3_data", ram_data, 8'h40);
        chk("drain3_wren", ram_wren, 1);
        tick();
        chk("drain_done_cnt", count, 0);
        chk("drain_done_empty", empty, 1);
        tick();
        chk("drop_not_written", ram_wren, 0);

        // Forwarding, youngest wins
        ram_grant = 1'b0;
        push(5'h13, 8'h11);
        push(5'h13, 8'h22);
        rd_addr = 5'h13;
        #1;
        chk("fwd_hit_13", fwd_hit, FWD ? 1 : 0);
        chk("fwd_data_13", fwd_data, FWD ? 8'h22 : 8'h00);
        rd_addr = 5'h14;
        #1;
        chk("fwd_hit_14", fwd_hit, 0);
        chk("fwd_data_14", fwd_data, 0);
        rd_addr = 5'h13;
        ram_grant = 1'b1;
        tick();
        chk("fwd_drain_addr0", ram_address, 5'h13);
        chk("fwd_drain_data0", ram_data, 8'h11);
        tick();
        chk("fwd_after_pop0", fwd_data, FWD ? 8'h22 : 8'h00);
        tick();
        chk("fwd_drain_data1", ram_data, 8'h22);
        chk("fwd_in_write_hit", fwd_hit, FWD ? 1 : 0);
        chk("fwd_in_write_data", fwd_data, FWD ? 8'h22 : 8'h00);
        tick();
        chk("fwd_gone_hit", fwd_hit, 0);
        chk("fwd_gone_cnt", count, 0);

        // Simultaneous push and pop at count=2 with tail wrap
        ram_grant = 1'b0;
        push(5'h08, 8'h81);
        push(5'h09, 8'h82);
        chk("pp_start_cnt", count, 2);
        ram_grant = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("pp_wren", ram_wren, 1);
            chk("pp_addr", ram_address, 5'h08 + 5'(i));
            chk("pp_data", ram_data, 8'h81 + 8'(i));
            push(5'h0A + 5'(i), 8'h83 + 8'(i));
            chk("pp_cnt", count, 2);
        end
        tick();
        chk("pp_tail0_addr", ram_address, 5'h0E);
        chk("pp_tail0_data", ram_data, 8'h87);
        tick();
        tick();
        chk("pp_tail1_addr", ram_address, 5'h0F);
        chk("pp_tail1_data", ram_data, 8'h88);
        tick();
        chk("pp_done_cnt", count, 0);

        // Grant drop during WRITE
        ram_grant = 1'b0;
        push(5'h07, 8'h77);
        push(5'h06, 8'h66);
        ram_grant = 1'b1;
        tick();
        chk("gd_wren", ram_wren, 1);
        chk("gd_addr", ram_address, 5'h07);
        ram_grant = 1'b0;
        tick();
        chk("gd_pop_cnt", count, 1);
        chk("gd_pop_wren", ram_wren, 0);
        tick(); tick();
        chk("gd_wait_wren", ram_wren, 0);
        chk("gd_wait_cnt", count, 1);
        ram_grant = 1'b1;
        tick();
        chk("gd_resume_wren", ram_wren, 1);
        chk("gd_resume_addr", ram_address, 5'h06);
        chk("gd_resume_data", ram_data, 8'h66);
        tick();
        chk("gd_done_cnt", count, 0);

        // Reset mid-drain
        ram_grant = 1'b0;
        push(5'h11, 8'hA1);
        push(5'h12, 8'hA2);
        push(5'h13, 8'hA3);
        ram_grant = 1'b1;
        rd_addr = 5'h11;
        tick();
        chk("rm_pre_wren", ram_wren, 1);
        chk("rm_pre_cnt", count, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rm_cnt", count, 0);
        chk("rm_wren", ram_wren, 0);
        chk("rm_empty", empty, 1);
        chk("rm_ready", wr_ready, 1);
        chk("rm_fwd_hit", fwd_hit, 0);
        tick();
        chk("rm_after_wren", ram_wren, 0);
        chk("rm_after_cnt", count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/write_buffer.md
# write_buffer

Write-through store buffer downstream of the two-way cache controller and upstream of the 32×8 backing RAM. It queues each store the cache accepts, frees the cache the same cycle, and drains entries to the RAM's single write port in FIFO order whenever the RAM port is granted. Reads of queued addresses are answered from the buffer, so the cache's miss fills never return stale RAM data.

## Interface
Parameters:
- DEPTH, 4: number of entries; power of two, minimum 2.
- ADDR_W, 5: RAM word address width (2-bit tag + 3-bit index).
- DATA_W, 8: data width.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_req  in  1  cache presents a store this cycle.
- wr_addr  in  ADDR_W  store address.
- wr_data  in  DATA_W  store data.
- wr_ready  out  1  buffer can accept a store; equals count < DEPTH.
- rd_addr  in  ADDR_W  address of the cache's current miss fill.
- fwd_hit  out  1  rd_addr matches a queued entry (combinational).
- fwd_data  out  DATA_W  data of the youngest matching entry; 0 when fwd_hit is 0.
- ram_grant  in  1  RAM port is free for the buffer this cycle.
- ram_address  out  ADDR_W  registered RAM write address.
- ram_data  out  DATA_W  registered RAM write data.
- ram_wren  out  1  registered RAM write enable.
- count  out  log2(DEPTH)+1  entries currently held, including the entry being written.
- empty  out  1  count == 0 and FSM in IDLE.

## Operation
- Storage is a circular FIFO with head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a separate count.
- Push happens when wr_req && wr_ready: the entry is written at tail, tail increments, and count increments. If wr_req is asserted while wr_ready is 0, the store is dropped and the cache must hold it.
- There is no coalescing. Two stores to the same address occupy two entries.
- Drain FSM:
  - IDLE: if count > 0 && ram_grant, load ram_address/ram_data from head, set ram_wren to 1, and go to WRITE. Otherwise stay in IDLE with ram_wren at 0.
  - WRITE: clear ram_wren to 0, pop head (head+1, count−1), and go to IDLE.
- Once ram_wren is issued, the write completes. Deasserting ram_grant during WRITE does not cancel it.
- On a simultaneous push and pop, count is unchanged and both pointers advance.
- When full, wr_ready stays 0 even in a cycle where a pop occurs. The freed slot becomes visible the next cycle.
- Forwarding compares rd_addr against all valid entries, including head while in WRITE. The youngest match (nearest tail) wins.

## Timing
- Reset values: head, tail and count are 0; FSM is in IDLE; ram_wren is 0; ram_address and ram_data are 0; wr_ready is 1; empty is 1; fwd_hit is 0.
- Reset asserted mid-operation discards all entries and any in-flight write at the next edge. ram_wren is 0 in the cycle after reset.
- Push latency: an entry pushed at edge N is visible to fwd_hit and count after edge N.
- Drain latency with ram_grant held high: ram_wren rises at edge N+1 after a push at edge N, and the entry is popped at edge N+2.
- Drain throughput is one entry per 2 cycles.
- fwd_hit and fwd_data are combinational from rd_addr and the entry array, with no added latency.

## Configuration
- WB_FORWARD_EN:
  - Defined: forwarding logic is present as described above.
  - Undefined: fwd_hit and fwd_data are tied to 0, and the cache must wait for empty before issuing a miss fill.
  - Push, drain and count behaviour is identical in both cases.

## Structure
- Shared package holds:
  - localparams WB_ADDR_W and WB_DATA_W.
  - the entry struct {addr, data}.
  - FSM state encodings WB_IDLE and WB_WRITE.
- One natural sub-module, wb_fwd_match: a priority match over the entries, ordered from tail to head, producing hit and data. It is instantiated only under WB_FORWARD_EN.

## Test plan
- Single store, grant high: push addr 0x0A, data 0x5C at edge 1. Expect ram_wren=1 with ram_address 0x0A and ram_data 0x5C after edge 2; count=0 and empty=1 after edge 3.
- Fill to full, grant low: 4 pushes set count=4 and wr_ready=0. A 5th wr_req is dropped and count stays 4. Raise grant: entries drain in push order, one per 2 cycles.
- Forwarding, youngest wins: push (0x13, 0x11) then (0x13, 0x22), grant low, rd_addr=0x13. Expect fwd_hit=1 and fwd_data=0x22. With rd_addr=0x14, expect fwd_hit=0 and fwd_data=0.
- Simultaneous push and pop at count=2: count stays 2, and the tail wraps from 3 to 0 correctly across 6 pushes.
- Grant drop during WRITE: the write to 0x07 still completes and is popped. The next entry waits until grant returns.
- Reset mid-drain with count=3 and ram_wren=1: after one edge, count=0, ram_wren=0, empty=1 and wr_ready=1.
